pc_ctrl: RTL and testbench
==========================

# pc_ctrl

Program-counter and pipeline-sequencing controller for the five-stage CPU core. It owns the PC register and the instruction-fetch enable. It turns per-stage stall requests into a 6-bit freeze vector and applies jump/branch redirects resolved in ID. It holds a redirect pending while fetch is frozen, and applies exception redirects with a pipeline flush.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value held during and immediately after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset: synchronous, active-high
- stall_req_if  in  1  fetch not ready (instruction memory busy)
- stall_req_id  in  1  ID stall request (load-use hazard)
- stall_req_ex  in  1  EX stall request (multi-cycle op)
- stall_req_mem  in  1  MEM stall request (data memory busy)
- branch_flag  in  1  ID resolved a taken jump/branch this cycle
- branch_addr  in  32  target of that jump/branch
- exc_flag  in  1  exception committed in MEM this cycle
- exc_addr  in  32  handler address
- pc  out  32  current fetch address (registered)
- ce  out  1  instruction fetch enable (registered)
- stall  out  6  freeze vector, bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB (combinational)
- flush  out  1  clear all pipeline registers (combinational)
- br_pending  out  1  redirect captured and not yet applied (registered)

## Operation
- Stall vector: the highest-numbered requesting stage wins.
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 0
- exc_flag=1 forces stall=0 and flush=1.
- Branch accepted = branch_flag && !stall[2] && !exc_flag. A branch held in a frozen ID is not accepted; ID re-presents it.
- States: RUN, BR_PEND (br_pending=1 iff BR_PEND). pc_tgt is a 32-bit pending target register.
- Per-edge priority when ce=1:
  1. exc_flag: pc<=exc_addr; state<=RUN; pending discarded.
  2. else stall[0]=0 and branch accepted: pc<=branch_addr.
  3. else stall[0]=0 and BR_PEND: pc<=pc_tgt; state<=RUN.
  4. else stall[0]=0: pc<=pc+4, modulo 2^32 (wraps 32'hFFFF_FFFC→0).
  5. else stall[0]=1 and branch accepted in RUN: pc_tgt<=branch_addr; state<=BR_PEND; pc holds.
  6. else pc holds.
- branch_flag while BR_PEND is an ISA violation (branch in delay slot). It is ignored and the pending target is kept.
- The delay-slot instruction is not squashed. A branch never asserts flush.
- When ce=0, pc holds RESET_PC and state stays RUN.

## Timing
- Reset values: pc=RESET_PC, ce=0, state=RUN (br_pending=0), pc_tgt=0.
- While rst=1: stall and flush follow their combinational rules from the inputs. Reset asserted mid-operation discards any pending redirect on that edge.
- First edge with rst=0: ce<=1, pc stays RESET_PC. The next unstalled edge advances pc.
- Redirect latency:
  - Accepted branch with fetch free: pc=branch_addr one edge later.
  - Accepted branch during IF freeze: pc=branch_addr on the first edge where stall[0]=0.
  - Exception: pc=exc_addr one edge later, regardless of stalls.
- stall and flush are purely combinational from the current-cycle inputs, with no registered delay.

## Test plan
- Reset then release, no stalls: pc=0 for 2 cycles after release, then 4, 8, 12; ce=1 from the first post-reset edge.
- stall_req_ex=1 with stall_req_if=1: stall=6'b001111, pc holds. Drop both: stall=0, pc advances by 4.
- pc=0x100, branch_flag=1, branch_addr=0x400, no stall: next pc=0x400; br_pending stays 0.
- pc=0x104, stall_req_if=1 for 3 cycles, branch_flag=1 with addr 0x800 in cycle 1 only: br_pending=1, pc holds 0x104; after stall drops, pc=0x800 and br_pending=0.
- BR_PEND with target 0x800, exc_flag=1, exc_addr=0x380, stall_req_mem=1 asserted: flush=1, stall=0, next pc=0x380, br_pending=0.
- pc=32'hFFFF_FFFC, no stall: next pc=0. branch_flag=1 with stall_req_id=1: no redirect and pc frozen.

Source files
------------

// File: rtl/pc_ctrl.sv
// PC register and pipeline sequencing: stall vector, flush,
// branch redirects (held while fetch is frozen) and exception redirects.
module pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req_if,
    input  logic        stall_req_id,
    input  logic        stall_req_ex,
    input  logic        stall_req_mem,
    input  logic        branch_flag,
    input  logic [31:0] branch_addr,
    input  logic        exc_flag,
    input  logic [31:0] exc_addr,
    output logic [31:0] pc,
    output logic        ce,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        br_pending
);

    typedef enum logic {
        RUN,
        BR_PEND
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc_tgt;
    logic [31:0] tgt_nx;
    logic [31:0] pc_nx;
    logic        br_acc;

    always_comb begin
        stall = 6'b000000;
        if (!exc_flag) begin
            priority case (1'b1)
                stall_req_mem: stall = 6'b011111;
                stall_req_ex:  stall = 6'b001111;
                stall_req_id:  stall = 6'b000111;
                stall_req_if:  stall = 6'b000011;
                default:       stall = 6'b000000;
            endcase
        end
    end

    assign flush      = exc_flag;
    assign br_pending = (state == BR_PEND);

    // A branch arriving in the delay slot of a pending one is dropped.
    assign br_acc = branch_flag && !stall[2] && !exc_flag
                    && (state == RUN);

    always_comb begin
        pc_nx    = pc;
        tgt_nx   = pc_tgt;
        state_nx = state;
        if (!ce) begin
            pc_nx    = RESET_PC;
            state_nx = RUN;
        end else if (exc_flag) begin
            pc_nx    = exc_addr;
            state_nx = RUN;
        end else if (!stall[0]) begin
            if (br_acc) begin
                pc_nx = branch_addr;
            end else if (state == BR_PEND) begin
                pc_nx    = pc_tgt;
                state_nx = RUN;
            end else begin
                pc_nx = pc + 32'd4;
            end
        end else if (br_acc) begin
            tgt_nx   = branch_addr;
            state_nx = BR_PEND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            ce     <= 1'b0;
            state  <= RUN;
            pc_tgt <= 32'h0;
        end else begin
            pc     <= pc_nx;
            ce     <= 1'b1;
            state  <= state_nx;
            pc_tgt <= tgt_nx;
        end
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_req_if = 1'b0;
    logic        stall_req_id = 1'b0;
    logic        stall_req_ex = 1'b0;
    logic        stall_req_mem = 1'b0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_addr = 32'h0;
    logic        exc_flag = 1'b0;
    logic [31:0] exc_addr = 32'h0;
    logic [31:0] pc;
    logic        ce;
    logic [5:0]  stall;
    logic        flush;
    logic        br_pending;

    int n_chk = 0;
    int n_fail = 0;

    // behavioural model state
    logic [31:0] m_pc = 32'h0;
    logic        m_ce = 1'b0;
    logic        m_pend = 1'b0;
    logic [31:0] m_tgt = 32'h0;

    pc_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_req_if (stall_req_if),
        .stall_req_id (stall_req_id),
        .stall_req_ex (stall_req_ex),
        .stall_req_mem(stall_req_mem),
        .branch_flag  (branch_flag),
        .branch_addr  (branch_addr),
        .exc_flag     (exc_flag),
        .exc_addr     (exc_addr),
        .pc           (pc),
        .ce           (ce),
        .stall        (stall),
        .flush        (flush),
        .br_pending   (br_pending)
    );

    always #5 clk = ~clk;

    // Number of frozen stages grows with the deepest requester.
    function automatic logic [5:0] exp_stall();
        int n;
        logic [6:0] v;
        n = 0;
        if (exc_flag) n = 0;
        else if (stall_req_mem) n = 5;
        else if (stall_req_ex) n = 4;
        else if (stall_req_id) n = 3;
        else if (stall_req_if) n = 2;
        v = (7'd1 << n) - 7'd1;
        return v[5:0];
    endfunction

    task automatic cycle();
        logic [31:0] npc;
        logic [31:0] ntgt;
        logic        nce;
        logic        npend;
        logic        fetch_frz;
        logic        id_frz;
        logic        acc;
        npc = m_pc;
        ntgt = m_tgt;
        nce = m_ce;
        npend = m_pend;
        fetch_frz = !exc_flag && (stall_req_if || stall_req_id
                    || stall_req_ex || stall_req_mem);
        id_frz = !exc_flag && (stall_req_id || stall_req_ex
                 || stall_req_mem);
        acc = branch_flag && !id_frz && !exc_flag && !m_pend;
        if (rst) begin
            npc = 32'h0;
            nce = 1'b0;
            npend = 1'b0;
            ntgt = 32'h0;
        end else if (!m_ce) begin
            nce = 1'b1;
            npc = 32'h0;
            npend = 1'b0;
        end else if (exc_flag) begin
            npc = exc_addr;
            npend = 1'b0;
        end else if (!fetch_frz) begin
            if (acc) npc = branch_addr;
            else if (m_pend) begin
                npc = m_tgt;
                npend = 1'b0;
            end else npc = m_pc + 32'd4;
        end else if (acc) begin
            ntgt = branch_addr;
            npend = 1'b1;
        end
        @(posedge clk);
        m_pc = npc;
        m_ce = nce;
        m_pend = npend;
        m_tgt = ntgt;
        #1;
    endtask

    task automatic clear_in();
        stall_req_if = 0;
        stall_req_id = 0;
        stall_req_ex = 0;
        stall_req_mem = 0;
        branch_flag = 0;
        exc_flag = 0;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1;
        stall_req_mem = 1;
        #1;
        n_chk++;
        if (stall !== 6'b011111) begin
            n_fail++;
            $display("FAIL rst_stall: got %b want 011111", stall);
        end
        cycle();
        cycle();
        stall_req_mem = 0;
        n_chk++;
        if (pc !== 32'h0 || ce !== 1'b0 || br_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_state: pc %h ce %b bp %b want 0 0 0",
                     pc, ce, br_pending);
        end
        rst = 0;
        cycle();
        n_chk++;
        if (pc !== 32'h0 || ce !== 1'b1) begin
            n_fail++;
            $display("FAIL release: pc %h ce %b want 0 1", pc, ce);
        end
        for (int i = 1; i <= 3; i++) begin
            cycle();
            n_chk++;
            if (pc !== 32'(4 * i)) begin
                n_fail++;
                $display("FAIL advance%0d: got %h want %h",
                         i, pc, 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall_vec();
        logic [31:0] p;
        stall_req_ex = 1;
        stall_req_if = 1;
        #1;
        n_chk++;
        if (stall !== 6'b001111) begin
            n_fail++;
            $display("FAIL stall_ex: got %b want 001111", stall);
        end
        p = pc;
        cycle();
        n_chk++;
        if (pc !== p) begin
            n_fail++;
            $display("FAIL stall_hold: got %h want %h", pc, p);
        end
        clear_in();
        #1;
        n_chk++;
        if (stall !== 6'b000000 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_none: got %b/%b want 0/0", stall, flush);
        end
        cycle();
        n_chk++;
        if (pc !== p + 32'd4) begin
            n_fail++;
            $display("FAIL stall_adv: got %h want %h", pc, p + 32'd4);
        end
    endtask

    task automatic test_branch();
        branch_flag = 1;
        branch_addr = 32'h100;
        cycle();
        branch_addr = 32'h400;
        cycle();
        branch_flag = 0;
        n_chk++;
        if (pc !== 32'h400 || br_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL branch: pc %h bp %b want 400 0", pc, br_pending);
        end
    endtask

    task automatic test_pending();
        branch_flag = 1;
        branch_addr = 32'h104;
        cycle();
        stall_req_if = 1;
        branch_addr = 32'h800;
        cycle();
        n_chk++;
        if (pc !== 32'h104 || br_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_set: pc %h bp %b want 104 1", pc, br_pending);
        end
        branch_addr = 32'h999c;
        cycle();
        branch_flag = 0;
        cycle();
        n_chk++;
        if (pc !== 32'h104 || br_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_hold: pc %h bp %b want 104 1", pc, br_pending);
        end
        stall_req_if = 0;
        cycle();
        n_chk++;
        if (pc !== 32'h800 || br_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_apply: pc %h bp %b want 800 0", pc, br_pending);
        end
    endtask

    task automatic test_exception();
        stall_req_if = 1;
        branch_flag = 1;
        branch_addr = 32'h800;
        cycle();
        branch_flag = 0;
        stall_req_mem = 1;
        exc_flag = 1;
        exc_addr = 32'h380;
        #1;
        n_chk++;
        if (flush !== 1'b1 || stall !== 6'b0) begin
            n_fail++;
            $display("FAIL exc_comb: flush %b stall %b want 1 0", flush, stall);
        end
        cycle();
        clear_in();
        n_chk++;
        if (pc !== 32'h380 || br_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_redir: pc %h bp %b want 380 0", pc, br_pending);
        end
    endtask

    task automatic test_wrap();
        branch_flag = 1;
        branch_addr = 32'hFFFF_FFFC;
        cycle();
        branch_flag = 0;
        cycle();
        n_chk++;
        if (pc !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap: got %h want 0", pc);
        end
        branch_flag = 1;
        branch_addr = 32'h500;
        stall_req_id = 1;
        cycle();
        clear_in();
        n_chk++;
        if (pc !== 32'h0 || br_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL id_frozen_br: pc %h bp %b want 0 0", pc, br_pending);
        end
    endtask

    task automatic test_mid_reset();
        stall_req_if = 1;
        branch_flag = 1;
        branch_addr = 32'h640;
        cycle();
        clear_in();
        rst = 1;
        cycle();
        n_chk++;
        if (br_pending !== 1'b0 || ce !== 1'b0 || pc !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_rst: pc %h ce %b bp %b want 0 0 0",
                     pc, ce, br_pending);
        end
        rst = 0;
        cycle();
        cycle();
        n_chk++;
        if (pc !== 32'h4) begin
            n_fail++;
            $display("FAIL post_rst: got %h want 4", pc);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            stall_req_if = ($urandom_range(0, 3) == 0);
            stall_req_id = ($urandom_range(0, 7) == 0);
            stall_req_ex = ($urandom_range(0, 9) == 0);
            stall_req_mem = ($urandom_range(0, 9) == 0);
            branch_flag = ($urandom_range(0, 3) == 0);
            branch_addr = $urandom & 32'hFFFF_FFFC;
            exc_flag = ($urandom_range(0, 19) == 0);
            exc_addr = $urandom & 32'hFFFF_FFFC;
            #1;
            n_chk++;
            if (stall !== exp_stall() || flush !== exc_flag) begin
                n_fail++;
                $display("FAIL rnd_comb%0d: stall %b flush %b want %b %b",
                         i, stall, flush, exp_stall(), exc_flag);
            end
            cycle();
            n_chk++;
            if (pc !== m_pc || ce !== m_ce || br_pending !== m_pend) begin
                n_fail++;
                $display("FAIL rnd_reg%0d: pc %h ce %b bp %b want %h %b %b",
                         i, pc, ce, br_pending, m_pc, m_ce, m_pend);
            end
        end
        rst = 0;
        clear_in();
    endtask

    initial begin
        #1;
        test_reset();
        test_stall_vec();
        test_branch();
        test_pending();
        test_exception();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
